wb_queue: RTL and testbench

- Write-back queue sitting directly upstream of the 8x16 register file.
- Accepts results from two producers, the ALU and the memory unit, over valid/ready handshakes, and buffers them in order in a small FIFO.
- Drains one entry per cycle onto the register file write port (writeregsel/writedata/write).
- Exposes a per-read-port pending/forward lookup so the decode stage can detect in-flight writes and bypass data not yet committed to the register file.

---
 rtl/wb_queue.sv | 122 ++++++++++++
 tb/tb_wb_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU/memory results in order and drains them onto the register file port.
// Ports: alu_*/mem_* producer handshakes, write/writeregsel/writedata to the regfile, rdN lookup, count, err.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [2:0]        alu_reg,
  input  logic [15:0]       alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [2:0]        mem_reg,
  input  logic [15:0]       mem_data,
  output logic              mem_ready,
  input  logic              wr_stall,
  output logic [2:0]        writeregsel,
  output logic [15:0]       writedata,
  output logic              write,
  input  logic [2:0]        rd1sel,
  input  logic [2:0]        rd2sel,
  output logic              pend1,
  output logic              pend2,
  output logic [15:0]       fwd1data,
  output logic [15:0]       fwd2data,
  output logic [PTRW:0]     count,
  output logic              err
);

  logic [2:0]       reg_q  [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW:0]    count_q;
  logic             err_q;

  logic             full;
  logic             empty;
  logic             push_mem;
  logic             push_alu;
  logic             push;
  logic             pop;
  logic [2:0]       push_reg;
  logic [15:0]      push_data;

  assign full  = (count_q == (PTRW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Memory wins; at most one push per cycle, no full-bypass.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign push_mem  = mem_valid && !full;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;
  assign push_reg  = push_mem ? mem_reg : alu_reg;
  assign push_data = push_mem ? mem_data : alu_data;

  assign write       = !empty && !wr_stall;
  assign pop         = write;
  assign writeregsel = empty ? 3'd0 : reg_q[head];
  assign writedata   = empty ? 16'd0 : data_q[head];

  assign count = count_q;
  assign err   = err_q;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTRW-1:0] idx;
    idx      = '0;
    pend1    = 1'b0;
    pend2    = 1'b0;
    fwd1data = 16'd0;
    fwd2data = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTRW'(i);
      if (vld_q[idx] && reg_q[idx] == rd1sel) begin
        pend1    = 1'b1;
        fwd1data = data_q[idx];
      end
      if (vld_q[idx] && reg_q[idx] == rd2sel) begin
        pend2    = 1'b1;
        fwd2data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= alu_valid && mem_valid &&
               (alu_reg == mem_reg);
      if (push) begin
        vld_q[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail]  <= push_reg;
      data_q[tail] <= push_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: queue-based reference model checked each cycle,
// plus directed literal checks and randomized traffic.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_reg = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_reg = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic        wr_stall = 1'b0;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [2:0]  rd1sel = '0;
  logic [2:0]  rd2sel = '0;
  logic        pend1, pend2;
  logic [15:0] fwd1data, fwd2data;
  logic [2:0]  count;
  logic        err;

  wb_queue #(.DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_stall(wr_stall), .writeregsel(writeregsel),
    .writedata(writedata), .write(write),
    .rd1sel(rd1sel), .rd2sel(rd2sel),
    .pend1(pend1), .pend2(pend2),
    .fwd1data(fwd1data), .fwd2data(fwd2data),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  bit   err_m;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_check;
    bit          full;
    bit          p1, p2;
    logic [15:0] f1, f2;
    full = (q.size() == DEPTH);
    p1 = 0; p2 = 0; f1 = '0; f2 = '0;
    foreach (q[i]) begin
      if (q[i].r == rd1sel) begin p1 = 1; f1 = q[i].d; end
      if (q[i].r == rd2sel) begin p2 = 1; f2 = q[i].d; end
    end
    chk("m_mem_ready", 32'(mem_ready), 32'(!full));
    chk("m_alu_ready", 32'(alu_ready),
        32'(!full && !mem_valid));
    chk("m_write", 32'(write),
        32'(q.size() != 0 && !wr_stall));
    chk("m_wsel", 32'(writeregsel),
        q.size() != 0 ? 32'(q[0].r) : 32'd0);
    chk("m_wdata", 32'(writedata),
        q.size() != 0 ? 32'(q[0].d) : 32'd0);
    chk("m_pend1", 32'(pend1), 32'(p1));
    chk("m_pend2", 32'(pend2), 32'(p2));
    chk("m_fwd1", 32'(fwd1data), 32'(f1));
    chk("m_fwd2", 32'(fwd2data), 32'(f2));
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_err", 32'(err), 32'(err_m));
  endtask

  task automatic model_update;
    bit   full;
    bit   do_pop;
    ent_t e;
    if (!rst) begin
      q.delete();
      err_m = 0;
      return;
    end
    full   = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && !wr_stall;
    if (do_pop) void'(q.pop_front());
    if (mem_valid && !full) begin
      e.r = mem_reg; e.d = mem_data;
      q.push_back(e);
    end else if (alu_valid && !full) begin
      e.r = alu_reg; e.d = alu_data;
      q.push_back(e);
    end
    err_m = alu_valid && mem_valid &&
            (alu_reg == mem_reg);
  endtask

  task automatic step;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle;
    alu_valid = 0;
    mem_valid = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    err_m = 0;

    // reset then idle
    rst = 0;
    step();
    step();
    rst = 1;
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_pend1", 32'(pend1), 32'd0);
    step();

    // single ALU push
    alu_valid = 1; alu_reg = 3; alu_data = 16'h1234;
    rd1sel = 3;
    step();
    idle();
    #1;
    chk("one_write", 32'(write), 32'd1);
    chk("one_wsel", 32'(writeregsel), 32'd3);
    chk("one_wdata", 32'(writedata), 32'h1234);
    chk("one_pend1", 32'(pend1), 32'd1);
    chk("one_fwd1", 32'(fwd1data), 32'h1234);
    step();
    chk("one_count", 32'(count), 32'd0);
    chk("one_pend1_clr", 32'(pend1), 32'd0);

    // priority and err, stalled so both are queued
    wr_stall = 1;
    rd1sel = 5;
    alu_valid = 1; alu_reg = 5; alu_data = 16'hAAAA;
    mem_valid = 1; mem_reg = 5; mem_data = 16'h5555;
    #1;
    chk("pri_alu_ready", 32'(alu_ready), 32'd0);
    step();
    mem_valid = 0;
    #1;
    chk("pri_err", 32'(err), 32'd1);
    chk("pri_head", 32'(writedata), 32'h5555);
    chk("pri_alu_ready2", 32'(alu_ready), 32'd1);
    step();
    idle();
    #1;
    chk("pri_err_clr", 32'(err), 32'd0);
    chk("pri_count", 32'(count), 32'd2);
    chk("pri_fwd1", 32'(fwd1data), 32'hAAAA);
    wr_stall = 0;
    #1;
    chk("pri_w1", 32'(writedata), 32'h5555);
    step();
    chk("pri_w2", 32'(writedata), 32'hAAAA);
    step();

    // fill under stall
    wr_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1;
      alu_reg = 3'(i);
      alu_data = 16'(16'h0011 * i);
      step();
    end
    alu_reg = 6; alu_data = 16'h0066;
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_alu_ready", 32'(alu_ready), 32'd0);
    chk("full_mem_ready", 32'(mem_ready), 32'd0);
    chk("full_write", 32'(write), 32'd0);
    step();
    chk("full_held", 32'(count), 32'd4);
    idle();
    wr_stall = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_write", 32'(write), 32'd1);
      chk("drain_wsel", 32'(writeregsel), 32'(i));
      chk("drain_wdata", 32'(writedata),
          32'(16'h0011 * i));
      step();
    end

    // wrap-around with continuous push/pop
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1;
      alu_reg = 3'(i);
      alu_data = 16'(16'h0100 + i);
      #1;
      if (i > 0) begin
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_wdata", 32'(writedata),
            32'(16'h0100 + i - 1));
      end
      step();
    end
    idle();
    step();

    // reset mid-operation
    wr_stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1;
      alu_reg = 3'(i + 1);
      alu_data = 16'(16'h0200 + i);
      step();
    end
    idle();
    rd1sel = 1; rd2sel = 2;
    #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 0;
    q.delete();
    err_m = 0;
    #1;
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_pend1", 32'(pend1), 32'd0);
    chk("mid_rst_pend2", 32'(pend2), 32'd0);
    step();
    rst = 1;
    wr_stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_write", 32'(write), 32'd0);
      step();
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      alu_valid = 1'($urandom % 2);
      alu_reg   = 3'($urandom);
      alu_data  = 16'($urandom);
      mem_valid = ($urandom % 3) == 0;
      mem_reg   = 3'($urandom);
      mem_data  = 16'($urandom);
      wr_stall  = ($urandom % 3) == 0;
      rd1sel    = 3'($urandom);
      rd2sel    = 3'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
